// File: rtl/uart_apb_regif_if.sv
// APB3 completer-side bus bundle for the UART register front-end.
interface uart_apb_regif_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [4:0]        PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_regif.sv
// APB3 register front-end for the UART core: strobe generation, baud/frame
// configuration and sticky W1C interrupt status with a level interrupt.
module uart_apb_regif #(
  parameter int unsigned APB_DWIDTH = 32,
  parameter logic [12:0] BAUD_RST   = 13'd1,
  parameter logic [2:0]  CFG_RST    = 3'b001
) (
  input  logic                    CLK,
  input  logic                    aresetn,
  uart_apb_regif_if.slave         apb,
  output logic                    CSN,
  output logic                    WEN,
  output logic                    OEN,
  output logic [7:0]              DATA_IN,
  input  logic [7:0]              DATA_OUT,
  input  logic                    TXRDY,
  input  logic                    RXRDY,
  input  logic                    PARITY_ERR,
  input  logic                    OVERFLOW,
  input  logic                    FRAMING_ERR,
  output logic [12:0]             BAUD_VAL,
  output logic [2:0]              BAUD_VAL_FRACTION,
  output logic                    BIT8,
  output logic                    PARITY_EN,
  output logic                    ODD_N_EVEN,
  output logic                    INTR
);

  localparam int unsigned NSTAT = 5;
  localparam int unsigned NIRQ  = 6;

  localparam logic [2:0] A_TXDATA   = 3'd0;
  localparam logic [2:0] A_RXDATA   = 3'd1;
  localparam logic [2:0] A_CTRL1    = 3'd2;
  localparam logic [2:0] A_CTRL2    = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;
  localparam logic [2:0] A_CTRL3    = 3'd5;
  localparam logic [2:0] A_IRQ_EN   = 3'd6;
  localparam logic [2:0] A_IRQ_STAT = 3'd7;

  logic [2:0]       addr;
  logic [7:0]       wdata;
  logic             setup;
  logic             acc_wr;
  logic             acc_rd;
  logic             tx_go;
  logic             tx_ovr;
  logic             rx_go;
  logic [NSTAT-1:0] stat_now;
  logic [NSTAT-1:0] stat_hist;
  logic [NIRQ-1:0]  irq_en;
  logic [NIRQ-1:0]  irq_stat;
  logic [NIRQ-1:0]  irq_set;
  logic [NIRQ-1:0]  irq_clr;
  logic [7:0]       rdata;
  logic             unused_bits;

  assign addr        = apb.PADDR[4:2];
  assign wdata       = apb.PWDATA[7:0];
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  assign setup  = apb.PSEL & ~apb.PENABLE;
  assign acc_wr = apb.PSEL &  apb.PENABLE &  apb.PWRITE;
  assign acc_rd = apb.PSEL &  apb.PENABLE & ~apb.PWRITE;

  // Strobe decisions are taken in setup so the strobe covers only the access cycle.
  assign tx_go  = setup &  apb.PWRITE & (addr == A_TXDATA) &  TXRDY;
  assign tx_ovr = setup &  apb.PWRITE & (addr == A_TXDATA) & ~TXRDY;
  assign rx_go  = setup & ~apb.PWRITE & (addr == A_RXDATA);

  assign stat_now = {FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY};
  assign irq_set  = {tx_ovr, stat_now & ~stat_hist};
  assign irq_clr  = (acc_wr && addr == A_IRQ_STAT) ? wdata[NIRQ-1:0] : '0;

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      CSN     <= 1'b1;
      WEN     <= 1'b1;
      OEN     <= 1'b1;
      DATA_IN <= 8'h00;
    end else begin
      CSN <= ~(tx_go | rx_go);
      WEN <= ~tx_go;
      OEN <= ~rx_go;
      if (tx_go) DATA_IN <= wdata;
    end
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      BAUD_VAL                        <= BAUD_RST;
      BAUD_VAL_FRACTION               <= 3'd0;
      {ODD_N_EVEN, PARITY_EN, BIT8}   <= CFG_RST;
      irq_en                          <= '0;
    end else if (acc_wr) begin
      case (addr)
        A_CTRL1:  BAUD_VAL[7:0] <= wdata;
        A_CTRL2: begin
          BAUD_VAL[12:8]                <= wdata[7:3];
          {ODD_N_EVEN, PARITY_EN, BIT8} <= wdata[2:0];
        end
        A_CTRL3:  BAUD_VAL_FRACTION <= wdata[2:0];
        A_IRQ_EN: irq_en <= wdata[NIRQ-1:0];
        default: ;
      endcase
    end
  end

  // Sticky status: a new rising edge in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      stat_hist <= '0;
      irq_stat  <= '0;
      INTR      <= 1'b0;
    end else begin
      stat_hist <= stat_now;
      irq_stat  <= (irq_stat & ~irq_clr) | irq_set;
      INTR      <= |(irq_stat & irq_en);
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (acc_rd) begin
      case (addr)
        A_RXDATA:   rdata = DATA_OUT;
        A_CTRL1:    rdata = BAUD_VAL[7:0];
        A_CTRL2:    rdata = {BAUD_VAL[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
        A_STATUS:   rdata = {2'b00, irq_stat[5:2], RXRDY, TXRDY};
        A_CTRL3:    rdata = {5'b00000, BAUD_VAL_FRACTION};
        A_IRQ_EN:   rdata = {2'b00, irq_en};
        A_IRQ_STAT: rdata = {2'b00, irq_stat};
        default:    rdata = 8'h00;
      endcase
    end
  end

  assign apb.PRDATA = APB_DWIDTH'(rdata);

endmodule

// File: tb/tb_uart_apb_regif.sv
// Self-checking bench for uart_apb_regif: per-feature tasks with a read-data scoreboard.
module tb_uart_apb_regif;

  logic        CLK = 1'b0;
  logic        aresetn;
  logic        CSN, WEN, OEN;
  logic [7:0]  DATA_IN;
  logic [7:0]  DATA_OUT;
  logic        TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR;
  logic [12:0] BAUD_VAL;
  logic [2:0]  BAUD_VAL_FRACTION;
  logic        BIT8, PARITY_EN, ODD_N_EVEN, INTR;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  uart_apb_regif_if #(.DWIDTH(32)) apb ();

  uart_apb_regif #(.APB_DWIDTH(32), .BAUD_RST(13'd1), .CFG_RST(3'b001)) dut (
    .CLK(CLK), .aresetn(aresetn), .apb(apb),
    .CSN(CSN), .WEN(WEN), .OEN(OEN), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR), .OVERFLOW(OVERFLOW),
    .FRAMING_ERR(FRAMING_ERR), .BAUD_VAL(BAUD_VAL), .BAUD_VAL_FRACTION(BAUD_VAL_FRACTION),
    .BIT8(BIT8), .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK) #1;
  endtask

  // One APB transfer; entered and left at posedge+1 so calls can run back-to-back.
  task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [2:0] s_setup,
                      output logic [2:0] s_acc);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = wd;
    @(negedge CLK) s_setup = {CSN, WEN, OEN};
    tick();
    apb.PENABLE = 1'b1;
    @(negedge CLK) begin s_acc = {CSN, WEN, OEN}; rd = apb.PRDATA; end
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [7] = '{5'h00, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
    logic [31:0] exps  [7] = '{32'h0, 32'h01, 32'h01, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] rd, e;
    logic [2:0]  ss, sa;
    @(negedge CLK);
    n_cmp++; if ({CSN, WEN, OEN} !== 3'b111) begin n_bad++; $display("FAIL reset_strobes: got %b expected 111", {CSN, WEN, OEN}); end
    n_cmp++; if (DATA_IN !== 8'h00) begin n_bad++; $display("FAIL reset_data_in: got %h expected 00", DATA_IN); end
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL reset_intr: got %b expected 0", INTR); end
    n_cmp++; if ({BAUD_VAL, BAUD_VAL_FRACTION, ODD_N_EVEN, PARITY_EN, BIT8} !== {13'd1, 3'd0, 3'b001}) begin
      n_bad++; $display("FAIL reset_cfg: got baud %h frac %h cfg %b expected 0001 0 001",
                        BAUD_VAL, BAUD_VAL_FRACTION, {ODD_N_EVEN, PARITY_EN, BIT8}); end
    @(posedge CLK) #1 aresetn = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      xfer(1'b0, addrs[i], 32'h0, rd, ss, sa);
      e = exp_q.pop_front();
      n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL reset_read[%h]: got %h expected %h", addrs[i], rd, e); end
      n_cmp++; if (sa !== 3'b111) begin n_bad++; $display("FAIL reset_read_strobe[%h]: got %b expected 111", addrs[i], sa); end
    end
  endtask

  task automatic test_tx();
    logic [31:0] rd, e;
    logic [2:0]  ss, sa;
    TXRDY = 1'b1;
    tick();
    xfer(1'b1, 5'h00, 32'hFFFF_FFA5, rd, ss, sa);
    n_cmp++; if (ss !== 3'b111) begin n_bad++; $display("FAIL tx_setup_strobe: got %b expected 111", ss); end
    n_cmp++; if (sa !== 3'b001) begin n_bad++; $display("FAIL tx_access_strobe: got %b expected 001", sa); end
    @(negedge CLK);
    n_cmp++; if ({CSN, WEN, OEN} !== 3'b111) begin n_bad++; $display("FAIL tx_after_strobe: got %b expected 111", {CSN, WEN, OEN}); end
    n_cmp++; if (DATA_IN !== 8'hA5) begin n_bad++; $display("FAIL tx_data_in: got %h expected a5", DATA_IN); end
    tick();
    xfer(1'b1, 5'h1C, 32'h3F, rd, ss, sa);
    TXRDY = 1'b0;
    tick();
    xfer(1'b1, 5'h00, 32'h5A, rd, ss, sa);
    n_cmp++; if (sa !== 3'b111) begin n_bad++; $display("FAIL txovr_strobe: got %b expected 111", sa); end
    n_cmp++; if (DATA_IN !== 8'hA5) begin n_bad++; $display("FAIL txovr_data_in: got %h expected a5", DATA_IN); end
    exp_q.push_back(32'h20);
    xfer(1'b0, 5'h1C, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL txovr_irq_stat: got %h expected %h", rd, e); end
    exp_q.push_back(32'h20);
    xfer(1'b0, 5'h10, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL txovr_status: got %h expected %h", rd, e); end
    xfer(1'b1, 5'h1C, 32'h3F, rd, ss, sa);
  endtask

  task automatic test_rx();
    logic [31:0] rd, e;
    logic [2:0]  ss, sa;
    DATA_OUT = 8'h3C; RXRDY = 1'b1;
    tick();
    exp_q.push_back(32'h3C);
    xfer(1'b0, 5'h04, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL rx_prdata: got %h expected %h", rd, e); end
    n_cmp++; if (ss !== 3'b111) begin n_bad++; $display("FAIL rx_setup_strobe: got %b expected 111", ss); end
    n_cmp++; if (sa !== 3'b010) begin n_bad++; $display("FAIL rx_access_strobe: got %b expected 010", sa); end
    @(negedge CLK);
    n_cmp++; if ({CSN, WEN, OEN} !== 3'b111) begin n_bad++; $display("FAIL rx_after_strobe: got %b expected 111", {CSN, WEN, OEN}); end
    tick();
    exp_q.push_back(32'h02);
    xfer(1'b0, 5'h1C, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL rx_irq_stat: got %h expected %h", rd, e); end
    exp_q.push_back(32'h02);
    xfer(1'b0, 5'h10, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL rx_status: got %h expected %h", rd, e); end
    RXRDY = 1'b0;
    xfer(1'b1, 5'h1C, 32'h3F, rd, ss, sa);
  endtask

  task automatic test_config();
    logic [31:0] rd, e;
    logic [2:0]  ss, sa;
    xfer(1'b1, 5'h08, 32'h34, rd, ss, sa);
    n_cmp++; if (sa !== 3'b111) begin n_bad++; $display("FAIL cfg_no_strobe: got %b expected 111", sa); end
    xfer(1'b1, 5'h0C, 32'hF9, rd, ss, sa);
    xfer(1'b1, 5'h14, 32'hFD, rd, ss, sa);
    @(negedge CLK);
    n_cmp++; if (BAUD_VAL !== 13'h1F34) begin n_bad++; $display("FAIL cfg_baud: got %h expected 1f34", BAUD_VAL); end
    n_cmp++; if ({ODD_N_EVEN, PARITY_EN, BIT8} !== 3'b001) begin n_bad++; $display("FAIL cfg_frame: got %b expected 001", {ODD_N_EVEN, PARITY_EN, BIT8}); end
    n_cmp++; if (BAUD_VAL_FRACTION !== 3'd5) begin n_bad++; $display("FAIL cfg_frac: got %0d expected 5", BAUD_VAL_FRACTION); end
    tick();
    exp_q.push_back(32'hF9);
    xfer(1'b0, 5'h0C, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL cfg_ctrl2_read: got %h expected %h", rd, e); end
    exp_q.push_back(32'h05);
    xfer(1'b0, 5'h14, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL cfg_ctrl3_read: got %h expected %h", rd, e); end
    @(negedge CLK);
    n_cmp++; if (apb.PRDATA !== 32'h0) begin n_bad++; $display("FAIL idle_prdata: got %h expected 0", apb.PRDATA); end
    tick();
  endtask

  task automatic test_irq();
    logic [31:0] rd, e;
    logic [2:0]  ss, sa;
    xfer(1'b1, 5'h18, 32'h04, rd, ss, sa);
    PARITY_ERR = 1'b1;
    tick();
    PARITY_ERR = 1'b0;
    @(negedge CLK);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL irq_intr_lag: got %b expected 0", INTR); end
    @(negedge CLK);
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL irq_intr_set: got %b expected 1", INTR); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL irq_intr_hold: got %b expected 1", INTR); end
    tick();
    // W1C access edge coincides with a fresh PARITY_ERR rise.
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 5'h1C; apb.PWDATA = 32'h04;
    tick();
    apb.PENABLE = 1'b1; PARITY_ERR = 1'b1;
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; PARITY_ERR = 1'b0;
    exp_q.push_back(32'h04);
    xfer(1'b0, 5'h1C, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL irq_set_wins: got %h expected %h", rd, e); end
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins_intr: got %b expected 1", INTR); end
    xfer(1'b1, 5'h1C, 32'h04, rd, ss, sa);
    repeat (2) @(negedge CLK);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL irq_intr_clear: got %b expected 0", INTR); end
    tick();
    exp_q.push_back(32'h00);
    xfer(1'b0, 5'h1C, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL irq_stat_cleared: got %h expected %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [2:0]  ss1, sa1, ss2, sa2;
    logic [7:0]  d1;
    TXRDY = 1'b1;
    tick();
    xfer(1'b1, 5'h00, 32'h11, rd, ss1, sa1);
    d1 = DATA_IN;
    xfer(1'b1, 5'h00, 32'h22, rd, ss2, sa2);
    n_cmp++; if (sa1 !== 3'b001) begin n_bad++; $display("FAIL b2b_first_pulse: got %b expected 001", sa1); end
    n_cmp++; if (d1 !== 8'h11) begin n_bad++; $display("FAIL b2b_first_data: got %h expected 11", d1); end
    n_cmp++; if (ss2 !== 3'b111) begin n_bad++; $display("FAIL b2b_gap: got %b expected 111", ss2); end
    n_cmp++; if (sa2 !== 3'b001) begin n_bad++; $display("FAIL b2b_second_pulse: got %b expected 001", sa2); end
    n_cmp++; if (DATA_IN !== 8'h22) begin n_bad++; $display("FAIL b2b_second_data: got %h expected 22", DATA_IN); end
    @(negedge CLK);
    n_cmp++; if ({CSN, WEN, OEN} !== 3'b111) begin n_bad++; $display("FAIL b2b_after: got %b expected 111", {CSN, WEN, OEN}); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e;
    logic [2:0]  ss, sa;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 5'h00; apb.PWDATA = 32'h99;
    tick();
    apb.PENABLE = 1'b1;
    #2;
    n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL mid_reset_pre: got %b expected 0", WEN); end
    aresetn = 1'b0;
    #1;
    n_cmp++; if ({CSN, WEN, OEN} !== 3'b111) begin n_bad++; $display("FAIL mid_reset_strobes: got %b expected 111", {CSN, WEN, OEN}); end
    n_cmp++; if (DATA_IN !== 8'h00) begin n_bad++; $display("FAIL mid_reset_data: got %h expected 00", DATA_IN); end
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    exp_q.push_back(32'h01);
    xfer(1'b0, 5'h08, 32'h0, rd, ss, sa);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL mid_reset_ctrl1: got %h expected %h", rd, e); end
  endtask

  initial begin
    aresetn = 1'b0;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    DATA_OUT = 8'h00; TXRDY = 1'b0; RXRDY = 1'b0;
    PARITY_ERR = 1'b0; OVERFLOW = 1'b0; FRAMING_ERR = 1'b0;
    repeat (3) @(posedge CLK);
    test_reset();
    test_tx();
    test_rx();
    test_config();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
